div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multicycle signed 32-bit divider. It is the responder to the control unit's divide handshake: it consumes the div_control start request and returns div_stop/div_zero.
- Operands come from the A/B registers. Results drive the mux_hi/mux_lo inputs that feed the HiLo register.
- Restoring algorithm, one quotient bit per cycle, with sign correction on the final step.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- div_control  input  1  start request from the control unit; a 0->1 transition starts an operation.
- a_in  input  WIDTH  dividend (signed, from A register).
- b_in  input  WIDTH  divisor (signed, from B register).
- hi_out  output  WIDTH  remainder.
- lo_out  output  WIDTH  quotient.
- div_stop  output  1  one-cycle done pulse.
- div_zero  output  1  one-cycle divide-by-zero pulse, coincident with div_stop.
- busy  output  1  high while an operation is in progress.

Behaviour:
- Reset: when reset=0, asynchronously clear state to IDLE and set hi_out=0, lo_out=0, div_stop=0, div_zero=0, busy=0, internal regs=0, and the div_control history bit to 0.
- Start detection: a registered copy ctl_q of div_control. start = div_control & ~ctl_q. Start is acted on only in IDLE.
  - A level held high never retriggers.
  - A 0->1 edge while busy is ignored, not queued.
- States: IDLE, RUN, FIX.
- IDLE, start seen with b_in==0:
  - Next edge: div_stop=1, div_zero=1, state stays IDLE.
  - hi_out/lo_out keep their previous values.
- IDLE, start seen with b_in!=0:
  - Capture |a_in| into the quotient shift reg and |b_in| into the divisor reg.
  - Clear the remainder reg, capture sign_q = a[31]^b[31] and sign_r = a[31].
  - Set cnt=WIDTH-1, busy=1, go to RUN.
  - Operands are sampled only at this edge; later changes on a_in/b_in have no effect.
- RUN, each edge:
  - {rem,quo} <<= 1.
  - If rem_shifted >= divisor: rem -= divisor and quo[0]=1.
  - If cnt==0, go to FIX; otherwise cnt-1.
  - 32 edges total.
- FIX, one edge:
  - lo_out = sign_q ? -quo : quo.
  - hi_out = sign_r ? -rem : rem.
  - div_stop=1, div_zero=0, busy=0, go to IDLE.
- Latency: the start edge is E0. div_stop is high during the cycle following E33 (33 cycles from start sampling to result). div_stop/div_zero self-clear on the next edge.
- Arithmetic:
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Magnitudes are computed as unsigned WIDTH bits, so |0x80000000| = 0x80000000.
  - The remainder compare uses WIDTH+1 bits to avoid carry loss.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000 (wraps), hi=0, div_zero=0. No overflow flag.
- hi_out/lo_out are written only in FIX; they hold their values in all other states.
- Reset asserted mid-RUN aborts the operation: no div_stop and outputs cleared. After release, an operation starts only on a fresh 0->1 of div_control, since ctl_q resets to 0. A div_control already high at release therefore counts as an edge.

Decomposition:
- Shared package/include div_mult_defs holds:
  - state encodings (IDLE=2'd0, RUN=2'd1, FIX=2'd2);
  - WIDTH default;
  - the CNT_W constant, reused by the future mult_unit.
- One natural sub-module, div_step: combinational shift/compare/subtract for one restoring iteration, taking {rem,quo,divisor} and returning next {rem,quo}. div_unit holds the FSM, counter, sign handling and output registers.

Test Plan:
- a=100, b=7, pulse div_control -> exactly 33 cycles later: div_stop=1 for 1 cycle, lo=14, hi=2, div_zero=0, busy high 33 cycles.
- a=-100 (0xFFFFFF9C), b=7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2); a=100, b=-7 -> lo=-14, hi=2.
- After a completed 100/7, a=5, b=0, raise div_control -> next cycle: div_stop=1 and div_zero=1 for 1 cycle, hi=2/lo=14 unchanged, busy never asserted.
- a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0; a=7, b=100 -> lo=0, hi=7.
- Hold div_control high across completion for 100 cycles -> exactly one div_stop. A 0->1 edge during RUN is ignored; changing a_in/b_in mid-RUN leaves the result unchanged.
- Assert reset=0 at RUN cycle 10, release, keep div_control low -> no div_stop, hi=lo=0, busy=0. A fresh edge then produces a correct result 33 cycles later.

Source files
------------

// File: rtl/div_mult_defs.sv
// rtl/div_mult_defs.sv - shared constants and state encodings for the divide/multiply units
package div_mult_defs;

    localparam int WIDTH = 32;
    // Iteration counter width; 2**CNT_W must exceed WIDTH.
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift, compare, conditional subtract
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    // One extra bit so the shifted remainder cannot lose its carry before the compare.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {1'b0, divisor};
        ge       = (shifted >= {1'b0, divisor});
        rem_next = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multicycle signed restoring divider answering the control unit's divide handshake
module div_unit #(
    parameter int WIDTH = div_mult_defs::WIDTH,
    parameter int CNT_W = div_mult_defs::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_control,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_stop,
    output logic             div_zero,
    output logic             busy
);

    import div_mult_defs::*;

    state_t           state, state_n;
    logic             ctl_q;
    logic             start;
    logic             b_zero;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [WIDTH-1:0] rem_n, quo_n;
    logic             sign_q, sign_r;
    logic [CNT_W-1:0] cnt;

    assign start  = div_control & ~ctl_q;
    assign b_zero = (b_in == '0);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvs),
        .rem_next (rem_n),
        .quo_next (quo_n)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start && !b_zero) state_n = RUN;
            RUN:     if (cnt == '0) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Magnitudes are plain unsigned WIDTH-bit values, so the most negative operand maps to itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctl_q    <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            div_stop <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            cnt      <= '0;
        end else begin
            ctl_q    <= div_control;
            div_stop <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b_zero) begin
                            div_stop <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            quo    <= a_in[WIDTH-1] ? -a_in : a_in;
                            dvs    <= b_in[WIDTH-1] ? -b_in : b_in;
                            rem    <= '0;
                            sign_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                            sign_r <= a_in[WIDTH-1];
                            cnt    <= CNT_W'(WIDTH - 1);
                            busy   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                FIX: begin
                    lo_out   <= sign_q ? -quo : quo;
                    hi_out   <= sign_r ? -rem : rem;
                    div_stop <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed and randomized self-checking bench for div_unit
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        div_control;
    logic [31:0] a_in, b_in;
    logic [31:0] hi_out, lo_out;
    logic        div_stop, div_zero, busy;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    div_unit dut (
        .clk         (clk),
        .reset       (reset),
        .div_control (div_control),
        .a_in        (a_in),
        .b_in        (b_in),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .div_stop    (div_stop),
        .div_zero    (div_zero),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Reference: signed division in 64-bit arithmetic, truncated back to 32 bits.
    task automatic model(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b != 0) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            exp_lo = q[31:0];
            exp_hi = r[31:0];
        end
    endtask

    task automatic div_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        int n;
        int busy_n;
        model(a, b);
        @(negedge clk);
        a_in = a;
        b_in = b;
        div_control = 1'b1;
        @(posedge clk);
        #1 div_control = 1'b0;
        n = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
        end while (!div_stop && n < 100);
        if (b == 0) begin
            check({tag, ".lat"}, n, 1);
            check({tag, ".busy"}, busy_n, 0);
            check({tag, ".zero"}, div_zero, 1);
        end else begin
            check({tag, ".lat"}, n, 34);
            check({tag, ".busy"}, busy_n, 33);
            check({tag, ".zero"}, div_zero, 0);
        end
        check({tag, ".hi"}, hi_out, exp_hi);
        check({tag, ".lo"}, lo_out, exp_lo);
        @(negedge clk);
        check({tag, ".stop_clr"}, {div_stop, div_zero}, 2'b00);
    endtask

    initial begin
        int stops;
        logic [31:0] got_hi, got_lo;
        reset = 1'b0;
        div_control = 1'b0;
        a_in = '0;
        b_in = '0;
        repeat (3) @(negedge clk);
        check("reset.hi", hi_out, 0);
        check("reset.lo", lo_out, 0);
        check("reset.flags", {div_stop, div_zero, busy}, 3'b000);
        reset = 1'b1;
        @(negedge clk);

        div_op(32'd100, 32'd7, "p100_7");
        check("p100_7.lo_const", lo_out, 32'd14);
        check("p100_7.hi_const", hi_out, 32'd2);
        div_op(32'd5, 32'd0, "div0");
        check("div0.hi_keep", hi_out, 32'd2);
        check("div0.lo_keep", lo_out, 32'd14);
        div_op(32'hFFFF_FF9C, 32'd7, "m100_7");
        check("m100_7.lo_const", lo_out, 32'hFFFF_FFF2);
        check("m100_7.hi_const", hi_out, 32'hFFFF_FFFE);
        div_op(32'd100, 32'hFFFF_FFF9, "p100_m7");
        div_op(32'h8000_0000, 32'hFFFF_FFFF, "minneg");
        check("minneg.lo_const", lo_out, 32'h8000_0000);
        check("minneg.hi_const", hi_out, 32'd0);
        div_op(32'd7, 32'd100, "p7_100");
        div_op(32'h8000_0000, 32'd1, "min_1");

        // Level held across completion, a mid-run edge and operand changes must not disturb the result.
        model(32'd1000, 32'd33);
        @(negedge clk);
        a_in = 32'd1000;
        b_in = 32'd33;
        div_control = 1'b1;
        stops = 0;
        got_hi = '0;
        got_lo = '0;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            if (i == 3) div_control = 1'b0;
            if (i == 5) div_control = 1'b1;
            if (i == 8) begin
                a_in = 32'd12345;
                b_in = 32'd3;
            end
            if (div_stop) begin
                stops++;
                got_hi = hi_out;
                got_lo = lo_out;
            end
        end
        check("hold.stops", stops, 1);
        check("hold.hi", got_hi, exp_hi);
        check("hold.lo", got_lo, exp_lo);
        div_control = 1'b0;
        @(negedge clk);

        // Reset in the middle of RUN aborts the operation.
        @(negedge clk);
        a_in = 32'd999;
        b_in = 32'd4;
        div_control = 1'b1;
        @(posedge clk);
        #1 div_control = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort.async_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        stops = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_stop) stops++;
        end
        check("abort.stops", stops, 0);
        check("abort.hi", hi_out, 0);
        check("abort.lo", lo_out, 0);
        check("abort.busy", busy, 0);
        div_op(32'd999, 32'd4, "after_abort");

        for (int k = 0; k < 16; k++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case (k % 4)
                1: rb = rb >> $urandom_range(31, 16);
                2: rb = -(rb >> $urandom_range(31, 8));
                3: if (k == 7) rb = 0;
                default: ;
            endcase
            div_op(ra, rb, $sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
